ras_ckpt: RTL and testbench

- Parametrised speculative return-address stack with per-branch checkpoints. Next generation of the branch unit's address-stack/backup logic.
- Serves jal/fork pushes and jr/end_parent pops at issue. Snapshots the stack pointer for every outstanding branch.
- Repairs entries overwritten under speculation, with recovery to any outstanding branch rather than only the oldest.
- Sits beside the branch unit; the branch unit drives alloc/commit/flush.

---
 rtl/ras_ckpt_pkg.sv | 19 +
 rtl/ras_backup_log.sv | 59 +++++
 rtl/ras_ckpt.sv | 135 +++++++++++++
 tb/tb_ras_ckpt.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_ckpt_pkg.sv
// Shared widths and record types for the checkpointed return-address stack.
package ras_ckpt_pkg;
   localparam int INST_MEM_WIDTH = 15;
   localparam int RAS_DEPTH_W    = 4;
   localparam int RAS_N_BR       = 4;
   localparam int RAS_N_LOG      = 4;
   localparam int BR_W           = $clog2(RAS_N_BR);

   typedef struct packed {
      logic [RAS_DEPTH_W-1:0] sp;
      logic [RAS_DEPTH_W:0]   depth;
   } ras_ckpt_t;

   typedef struct packed {
      logic [RAS_DEPTH_W-1:0]    slot;
      logic [INST_MEM_WIDTH-1:0] old;
      logic [BR_W-1:0]           tag;
   } ras_log_t;
endpackage

// File: rtl/ras_backup_log.sv
// Age-ordered log of stack slots overwritten under speculation; drops by tag
// on commit or flush and compacts survivors toward index 0 in one cycle.
module ras_backup_log
   import ras_ckpt_pkg::*;
#(
   parameter int N_LOG = RAS_N_LOG
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       commit,
   input  logic                       flush,
   input  logic [BR_W-1:0]            flush_idx,
   input  logic                       append,
   input  ras_log_t                   append_entry,
   output ras_log_t                   ents [N_LOG],
   output logic [$clog2(N_LOG+1)-1:0] cnt,
   output logic [N_LOG-1:0]           restore_mask
);
   localparam int CNT_W = $clog2(N_LOG + 1);

   ras_log_t         ents_n [N_LOG];
   logic [CNT_W-1:0] cnt_n;

   always_comb begin
      for (int i = 0; i < N_LOG; i++)
         restore_mask[i] = flush && (CNT_W'(i) < cnt) && (ents[i].tag >= flush_idx);
   end

   // Survivors keep their age order; commit renumbers tags to the shifted queue.
   always_comb begin
      int k;
      ents_n = ents;
      k = 0;
      for (int i = 0; i < N_LOG; i++) begin
         if ((CNT_W'(i) < cnt) && !(commit && (ents[i].tag == '0)) && !restore_mask[i]) begin
            ents_n[k] = ents[i];
            if (commit)
               ents_n[k].tag = ents[i].tag - BR_W'(1);
            k++;
         end
      end
      if (append && (k < N_LOG)) begin
         ents_n[k] = append_entry;
         k++;
      end
      cnt_n = CNT_W'(k);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else
         cnt <= cnt_n;
   end

   always_ff @(posedge clk) begin
      ents <= ents_n;
   end
endmodule

// File: rtl/ras_ckpt.sv
// Speculative return-address stack with per-branch sp/depth checkpoints and
// log-based repair of overwritten slots on recovery to any outstanding branch.
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int ADDR_W  = INST_MEM_WIDTH,
   parameter int DEPTH_W = RAS_DEPTH_W,
   parameter int N_BR    = RAS_N_BR,
   parameter int N_LOG   = RAS_N_LOG
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push,
   input  logic [ADDR_W-1:0]       push_addr,
   output logic                    push_ready,
   input  logic                    pop,
   input  logic                    br_alloc,
   output logic                    br_alloc_ready,
   input  logic                    br_commit,
   input  logic                    flush,
   input  logic [$clog2(N_BR)-1:0] flush_idx,
   output logic [ADDR_W-1:0]       return_addr,
   output logic [$clog2(N_BR):0]   ckpt_count,
   output logic [DEPTH_W:0]        depth
);
   localparam int SLOTS  = 2**DEPTH_W;
   localparam int CNT_W  = $clog2(N_BR) + 1;
   localparam int LCNT_W = $clog2(N_LOG + 1);

   logic [ADDR_W-1:0]  stack   [SLOTS];
   logic [ADDR_W-1:0]  stack_n [SLOTS];
   logic [DEPTH_W-1:0] sp, sp_n, slot_up;
   logic [DEPTH_W:0]   depth_n;
   ras_ckpt_t          ckpt_q [N_BR];
   ras_ckpt_t          ckpt_n [N_BR];
   logic [CNT_W-1:0]   count_n, cnt_base;
   logic               commit_in, commit, spec, freed, push_do, pop_do, alloc_do;
   ras_log_t           log_ents [N_LOG];
   ras_log_t           log_new;
   logic [LCNT_W-1:0]  log_cnt;
   logic [N_LOG-1:0]   restore_mask;

   // cnt_base is the queue length once this cycle's commit has retired the head.
   assign commit_in      = br_commit && (ckpt_count != '0);
   assign commit         = commit_in && !flush;
   assign cnt_base       = ckpt_count - CNT_W'(commit_in);
   assign spec           = (cnt_base != '0);
   assign freed          = (log_cnt != '0) && (log_ents[0].tag == '0) && commit_in;
   assign push_ready     = !spec || (log_cnt < LCNT_W'(N_LOG)) || freed;
   assign br_alloc_ready = (ckpt_count < CNT_W'(N_BR)) || br_commit;
   assign push_do        = push && push_ready && !flush;
   assign pop_do         = pop && !push && !flush;
   assign alloc_do       = br_alloc && br_alloc_ready && !flush;
   assign slot_up        = sp + DEPTH_W'(1);
   assign log_new        = '{slot: slot_up, old: stack[slot_up],
                             tag: BR_W'(cnt_base - CNT_W'(1))};

   ras_backup_log #(.N_LOG(N_LOG)) u_log (
      .clk          (clk),
      .reset_n      (reset_n),
      .commit       (commit),
      .flush        (flush),
      .flush_idx    (flush_idx),
      .append       (push_do && spec),
      .append_entry (log_new),
      .ents         (log_ents),
      .cnt          (log_cnt),
      .restore_mask (restore_mask)
   );

   always_comb begin
      ckpt_n  = ckpt_q;
      count_n = ckpt_count;
      if (flush) begin
         count_n = {1'b0, flush_idx};
      end else begin
         if (commit) begin
            for (int i = 0; i < N_BR - 1; i++)
               ckpt_n[i] = ckpt_q[i+1];
         end
         count_n = cnt_base;
         if (alloc_do) begin
            ckpt_n[cnt_base[CNT_W-2:0]] = '{sp: sp, depth: depth};
            count_n = cnt_base + CNT_W'(1);
         end
      end
   end

   // Repair walks youngest to oldest so the oldest saved value of a slot lands last.
   always_comb begin
      stack_n = stack;
      sp_n    = sp;
      depth_n = depth;
      if (flush) begin
         sp_n    = ckpt_q[flush_idx].sp;
         depth_n = ckpt_q[flush_idx].depth;
         for (int i = N_LOG - 1; i >= 0; i--) begin
            if (restore_mask[i])
               stack_n[log_ents[i].slot] = log_ents[i].old;
         end
      end else if (push_do) begin
         stack_n[slot_up] = push_addr;
         sp_n = slot_up;
         if (depth != (DEPTH_W+1)'(SLOTS))
            depth_n = depth + (DEPTH_W+1)'(1);
      end else if (pop_do) begin
         sp_n = sp - DEPTH_W'(1);
         if (depth != '0)
            depth_n = depth - (DEPTH_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stack       <= '{default: '0};
         sp          <= DEPTH_W'(SLOTS - 1);
         depth       <= '0;
         ckpt_count  <= '0;
         return_addr <= '0;
      end else begin
         stack       <= stack_n;
         sp          <= sp_n;
         depth       <= depth_n;
         ckpt_count  <= count_n;
         return_addr <= stack_n[sp_n];
      end
   end

   always_ff @(posedge clk) begin
      ckpt_q <= ckpt_n;
   end

   flush_idx_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
      flush |-> (CNT_W'(flush_idx) < ckpt_count));
endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based stack model.
module tb_ras_ckpt;
   localparam int ADDR_W = 15;
   localparam int N_BR   = 4;
   localparam int N_LOG  = 4;
   localparam int SLOTS  = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              push = 1'b0, pop = 1'b0, br_alloc = 1'b0, br_commit = 1'b0, flush = 1'b0;
   logic [ADDR_W-1:0] push_addr = '0;
   logic [1:0]        flush_idx = '0;
   logic              push_ready, br_alloc_ready;
   logic [ADDR_W-1:0] return_addr;
   logic [2:0]        ckpt_count;
   logic [4:0]        depth;

   always #5 clk = ~clk;

   ras_ckpt dut (
      .clk(clk), .reset_n(reset_n), .push(push), .push_addr(push_addr),
      .push_ready(push_ready), .pop(pop), .br_alloc(br_alloc),
      .br_alloc_ready(br_alloc_ready), .br_commit(br_commit), .flush(flush),
      .flush_idx(flush_idx), .return_addr(return_addr), .ckpt_count(ckpt_count),
      .depth(depth)
   );

   typedef struct { int sp; int depth; } ck_t;
   typedef struct { int slot; int old; int tag; } lg_t;

   int  stk [SLOTS];
   int  msp, mdepth;
   ck_t ckq [$];
   lg_t lgq [$];
   int  checks = 0, errors = 0;
   bit  cmp_en = 1'b0;

   function automatic void check(string name, logic [31:0] act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      foreach (stk[i]) stk[i] = 0;
      msp = SLOTS - 1;
      mdepth = 0;
      ckq.delete();
      lgq.delete();
   endfunction

   function automatic bit m_commit();
      return br_commit && (ckq.size() > 0);
   endfunction

   function automatic int m_base();
      return ckq.size() - int'(m_commit());
   endfunction

   function automatic bit m_pready();
      return (m_base() == 0) || (lgq.size() < N_LOG) ||
             ((lgq.size() > 0) && (lgq[0].tag == 0) && m_commit());
   endfunction

   function automatic bit m_aready();
      return (ckq.size() < N_BR) || br_commit;
   endfunction

   task automatic model_step();
      lg_t keep [$];
      bit  c, pr, ar;
      int  base, pre_sp, pre_d, s, fi;
      if (flush) begin
         fi = int'(flush_idx);
         for (int i = lgq.size() - 1; i >= 0; i--)
            if (lgq[i].tag >= fi) stk[lgq[i].slot] = lgq[i].old;
         foreach (lgq[i]) if (lgq[i].tag < fi) keep.push_back(lgq[i]);
         lgq = keep;
         msp = ckq[fi].sp;
         mdepth = ckq[fi].depth;
         while (ckq.size() > fi) void'(ckq.pop_back());
      end else begin
         c = m_commit(); base = m_base(); pr = m_pready(); ar = m_aready();
         pre_sp = msp; pre_d = mdepth;
         if (c) begin
            void'(ckq.pop_front());
            foreach (lgq[i]) if (lgq[i].tag != 0) keep.push_back('{lgq[i].slot, lgq[i].old, lgq[i].tag - 1});
            lgq = keep;
         end
         if (br_alloc && ar) ckq.push_back('{pre_sp, pre_d});
         if (push && pr) begin
            s = (msp + 1) % SLOTS;
            if (base != 0) lgq.push_back('{s, stk[s], base - 1});
            stk[s] = int'(push_addr);
            msp = s;
            if (mdepth < SLOTS) mdepth++;
         end else if (pop && !push) begin
            msp = (msp + SLOTS - 1) % SLOTS;
            if (mdepth > 0) mdepth--;
         end
      end
   endtask

   task automatic set_in(bit pu, int a, bit po, bit al, bit co, bit fl, int fi);
      push = pu; push_addr = ADDR_W'(a); pop = po; br_alloc = al;
      br_commit = co; flush = fl; flush_idx = 2'(fi);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      push = 1'b0; pop = 1'b0; br_alloc = 1'b0; br_commit = 1'b0; flush = 1'b0;
   endtask

   task automatic cyc(bit pu, int a, bit po, bit al, bit co, bit fl, int fi);
      set_in(pu, a, po, al, co, fl, fi);
      step();
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      check("rst_return_addr", return_addr, 0);
      check("rst_depth", depth, 0);
      check("rst_ckpt_count", ckpt_count, 0);
      check("rst_push_ready", push_ready, 1);
      check("rst_alloc_ready", br_alloc_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial forever begin
      @(negedge clk);
      if (cmp_en && reset_n) begin
         check("return_addr", return_addr, stk[msp]);
         check("depth", depth, mdepth);
         check("ckpt_count", ckpt_count, ckq.size());
         check("push_ready", push_ready, m_pready());
         check("br_alloc_ready", br_alloc_ready, m_aready());
      end
   end

   initial begin
      bit pu, po, al, co, fl;
      int fi;
      model_reset();
      do_reset();
      cmp_en = 1'b1;

      // Non-speculative push/push/pop.
      cyc(1, 'h10, 0, 0, 0, 0, 0);
      cyc(1, 'h20, 0, 0, 0, 0, 0);
      check("t1_ret_after_push", return_addr, 'h20);
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("t1_ret_after_pop", return_addr, 'h10);
      check("t1_depth", depth, 1);

      // Single branch, overwrite under speculation, flush to it.
      do_reset();
      cyc(1, 'h10, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h30, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(1, 'h40, 0, 0, 0, 0, 0);
      check("t2_ret_spec", return_addr, 'h40);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("t2_ret_flush", return_addr, 'h10);
      check("t2_ckpt", ckpt_count, 0);
      check("t2_depth", depth, 1);

      // Two branches, flush the younger only, then the older.
      do_reset();
      cyc(1, 'h11, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h50, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h60, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1);
      check("t3_ret_flush1", return_addr, 'h50);
      check("t3_ckpt_flush1", ckpt_count, 1);
      check("t3_depth_flush1", depth, 2);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("t3_ret_flush0", return_addr, 'h11);
      check("t3_ckpt_flush0", ckpt_count, 0);

      // Full log blocks pushes until a commit frees tag-0 entries.
      do_reset();
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h31, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h32, 0, 0, 0, 0, 0);
      cyc(1, 'h33, 0, 0, 0, 0, 0);
      cyc(1, 'h34, 0, 0, 0, 0, 0);
      set_in(1, 'h35, 0, 0, 0, 0, 0);
      #1 check("t4_full_push_ready", push_ready, 0);
      set_in(1, 'h35, 0, 0, 1, 0, 0);
      #1 check("t4_freed_push_ready", push_ready, 1);
      step();
      check("t4_ret", return_addr, 'h35);
      check("t4_ckpt", ckpt_count, 1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("t4_ret_flush", return_addr, 'h31);
      check("t4_depth_flush", depth, 1);

      // Overflow: 17 pushes saturate depth and wrap sp.
      do_reset();
      for (int i = 0; i <= SLOTS; i++) cyc(1, 'h100 + i, 0, 0, 0, 0, 0);
      check("t5_ret", return_addr, 'h110);
      check("t5_depth", depth, 16);
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("t5_ret_pop", return_addr, 'h10f);
      check("t5_depth_pop", depth, 15);

      // Asynchronous reset with three checkpoints and two log entries live.
      do_reset();
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h21, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 'h22, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      check("t6_ckpt_before", ckpt_count, 3);
      check("t6_ret_before", return_addr, 'h22);
      do_reset();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         fl = (ckq.size() > 0) && ($urandom_range(0, 99) < 6);
         fi = (ckq.size() > 0) ? int'($urandom_range(0, ckq.size() - 1)) : 0;
         co = (ckq.size() > 0) && ($urandom_range(0, 99) < 15);
         pu = $urandom_range(0, 99) < 45;
         po = $urandom_range(0, 99) < 30;
         al = $urandom_range(0, 99) < 25;
         set_in(pu, int'($urandom), po, al, co, fl, fi);
         step();
         if ((n % 997) == 500) do_reset();
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
